key_event_master: RTL and testbench
===================================

KEY_EVENT_MASTER -- requirements
Module: key_event_master

Interface
REQ-001 SHALL have parameter POLL_CYCLES, default 50000, idle cycles between autonomous scans (valid 2..2^20).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port m_address  output  2  Avalon-MM word address to key PIO slave.
REQ-006 SHALL have port m_chipselect  output  1  Avalon-MM slave select.
REQ-007 SHALL have port m_write_n  output  1  active-low write strobe.
REQ-008 SHALL have port m_writedata  output  32  write data.
REQ-009 SHALL have port m_readdata  input  32  slave read data; registered, one-cycle latency, no waitrequest.
REQ-010 SHALL have port irq_in  input  1  slave level interrupt.
REQ-011 SHALL have ports evt_valid output 1, evt_ready input 1, evt_level output 1: key event stream (valid/ready), key level at event.
REQ-012 SHALL have ports evt_overflow output 1 (sticky drop flag) and ovf_clr input 1 (single-cycle clear).

Function
REQ-013 States: INIT, IDLE, RD_EC, WT_EC, CLR_EC, RD_DAT, WT_DAT, PUSH.
REQ-014 INIT: one-cycle write, address 2, writedata 32'h1 (enable irq mask); then IDLE.
REQ-015 IDLE: m_chipselect=0, m_write_n=1, m_address=3; leave to RD_EC when irq_in=1 or scan trigger (REQ-029).
REQ-016 RD_EC/WT_EC: m_address=3, m_chipselect=1 in RD_EC, address held through WT_EC; m_readdata[0] sampled at clock edge ending WT_EC.
REQ-017 Sampled bit0=0: return to IDLE, no event; bit0=1: CLR_EC.
REQ-018 CLR_EC: one-cycle write, address 3, writedata 0; then RD_DAT.
REQ-019 RD_DAT/WT_DAT: address 0, same timing as REQ-016; m_readdata[0] captured as level.
REQ-020 PUSH: enqueue level if FIFO not full or pop in same cycle; otherwise drop and set evt_overflow; then IDLE.
REQ-021 Scan latency: trigger in IDLE to PUSH = 6 cycles; no bus write except INIT and CLR_EC.
REQ-022 FIFO: first-word-fall-through; evt_valid=not empty; pop when evt_valid & evt_ready; evt_level=head entry.
REQ-023 Simultaneous push+pop on full FIFO: both occur, occupancy unchanged, no overflow.
REQ-024 Simultaneous ovf_clr and new drop: evt_overflow stays 1 (set wins).
REQ-025 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-026 irq_in held high: rescans back-to-back; each scan with edge_capture=0 yields no event.
REQ-027 Edge arriving between RD_EC sample and CLR_EC is lost by design.

Reset
REQ-028 On reset_n=0 asynchronously: state INIT, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, FIFO empty, evt_valid=0, evt_level=0, evt_overflow=0, poll counter 0; reset mid-scan aborts without completing the bus sequence; INIT reissued after release.

Configuration
REQ-029 Macro KEY_EVT_POLL_EN defined: poll counter increments in IDLE, triggers scan at POLL_CYCLES-1 and clears on leaving IDLE; undefined: counter absent, scans triggered only by irq_in.

Verification
REQ-030 Reset release -> first cycle: write address 2, data 32'h1; then IDLE with chipselect 0.
REQ-031 irq_in=1, slave edge_capture=1, data_in=1 -> write address 3 data 0, one event evt_level=1 within 6 cycles.
REQ-032 evt_ready=0, five press events, FIFO_DEPTH=4 -> four queued, evt_overflow=1; ovf_clr -> 0.
REQ-033 Full FIFO, evt_ready=1 at PUSH cycle -> occupancy stays 4, evt_overflow=0.
REQ-034 KEY_EVT_POLL_EN, POLL_CYCLES=8, irq_in=0 -> RD_EC every 8 idle cycles plus scan length; undefined -> no bus activity.
REQ-035 reset_n low during WT_DAT -> outputs reset values immediately, no event pushed.

Source files
------------

// File: rtl/key_event_master.sv
// key_event_master: scans a key PIO slave over Avalon-MM and queues key events (KEY_EVT_POLL_EN adds autonomous polling)
module key_event_master #(
    parameter int POLL_CYCLES = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        irq_in,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic        evt_level,
    output logic        evt_overflow,
    input  logic        ovf_clr
);
    localparam logic [2:0] INIT = 3'd0, IDLE = 3'd1, RD_EC = 3'd2, WT_EC = 3'd3,
                           CLR_EC = 3'd4, RD_DAT = 3'd5, WT_DAT = 3'd6, PUSH = 3'd7;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [2:0]            state_q, state_d;
    logic                  level_q, level_d;
    logic [1:0]            addr_q, addr_d;
    logic                  cs_q, cs_d, wn_q, wn_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [FIFO_DEPTH-1:0] mem_q;
    logic [AW-1:0]         wr_q, rd_q;
    logic [AW:0]           cnt_q;
    logic                  ovf_q;
    logic                  poll_hit, full, push, pop, drop;
    logic                  unused_rd;

    assign unused_rd = ^m_readdata[31:1];

`ifdef KEY_EVT_POLL_EN
    localparam int PW = $clog2(POLL_CYCLES);
    logic [PW-1:0] poll_q;
    assign poll_hit = poll_q == PW'(POLL_CYCLES - 1);
    // idle-cycle counter; restarts whenever the FSM is not staying in IDLE
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) poll_q <= '0;
        else poll_q <= (state_q == IDLE && state_d == IDLE) ? poll_q + 1'b1 : '0;
`else
    assign poll_hit = POLL_CYCLES == 0;
`endif

    // scan sequencer: check edge capture, clear it, read the key level, queue it
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            INIT:    state_d = IDLE;
            IDLE:    state_d = (irq_in || poll_hit) ? RD_EC : IDLE;
            RD_EC:   state_d = WT_EC;
            WT_EC:   state_d = m_readdata[0] ? CLR_EC : IDLE;
            CLR_EC:  state_d = RD_DAT;
            RD_DAT:  state_d = WT_DAT;
            WT_DAT:  begin
                state_d = PUSH;
                level_d = m_readdata[0];
            end
            default: state_d = IDLE;
        endcase
    end

    // bus outputs are registered from the next state; leaving INIT issues the irq-mask write
    always_comb begin
        cs_d    = state_q == INIT || state_d == RD_EC || state_d == CLR_EC || state_d == RD_DAT;
        wn_d    = !(state_q == INIT || state_d == CLR_EC);
        addr_d  = state_q == INIT ? 2'd2 : (state_d == RD_DAT || state_d == WT_DAT || state_d == PUSH) ? 2'd0 : 2'd3;
        wdata_d = state_q == INIT ? 32'h1 : 32'h0;
    end

    assign full         = cnt_q == (AW + 1)'(FIFO_DEPTH);
    assign evt_valid    = cnt_q != '0;
    assign pop          = evt_valid && evt_ready;
    assign push         = state_q == PUSH && (!full || pop);
    assign drop         = state_q == PUSH && full && !pop;
    assign evt_level    = evt_valid && mem_q[rd_q];
    assign evt_overflow = ovf_q;
    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_writedata  = wdata_q;

    // FSM and bus registers
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= INIT;
            level_q <= 1'b0;
            addr_q  <= 2'd0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wdata_q <= wdata_d;
        end

    // event FIFO and sticky overflow; a drop outranks a same-cycle clear
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= level_q;
            wr_q  <= push ? wr_q + 1'b1 : wr_q;
            rd_q  <= pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            ovf_q <= drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        end
endmodule

// File: tb/tb_key_event_master.sv
// tb_key_event_master: directed bench for key_event_master with a small key PIO slave model
module tb_key_event_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] rdata = '0;
    logic        irq_in;
    logic        evt_valid, evt_level, evt_overflow;
    logic        evt_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        ec = 1'b0, din = 1'b0, mask = 1'b0, ec_set = 1'b0, irq_force = 1'b0;
    int          tests = 0, fails = 0;

    key_event_master #(.POLL_CYCLES(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(rdata), .irq_in(irq_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_level(evt_level),
        .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    assign irq_in = irq_force | (mask & ec);

    // key PIO slave: registered reads, any write to edge_capture clears it
    always @(posedge clk) begin
        if (m_chipselect && m_write_n)
            rdata <= {31'b0, m_address == 2'd3 ? ec : m_address == 2'd0 ? din : m_address == 2'd2 ? mask : 1'b0};
        if (m_chipselect && !m_write_n && m_address == 2'd2) mask <= m_writedata[0];
        if (ec_set) ec <= 1'b1;
        else if (m_chipselect && !m_write_n && m_address == 2'd3) ec <= 1'b0;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one key event: edge latched, full scan, optional ready/clear during the PUSH cycle
    task automatic press(input logic lvl, input logic rdy, input logic clr);
        ec_set = 1'b1;
        din = lvl;
        step(1);
        ec_set = 1'b0;
        step(6);
        evt_ready = rdy;
        ovf_clr = clr;
        step(1);
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
    endtask

    // bit i of lv is the level expected at the i-th pop
    task automatic drain4(input string tag, input logic [3:0] lv);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
            chk({tag, "_level"}, 32'(evt_level), 32'(lv[i]));
            evt_ready = 1'b1;
            step(1);
            evt_ready = 1'b0;
        end
        chk({tag, "_empty"}, 32'(evt_valid), 32'd0);
    endtask

    initial begin
        int act, rd, wr, first, second;
        step(2);
        chk("rst_cs", 32'(m_chipselect), 32'd0);
        chk("rst_wn", 32'(m_write_n), 32'd1);
        chk("rst_addr", 32'(m_address), 32'd0);
        chk("rst_wdata", m_writedata, 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_level", 32'(evt_level), 32'd0);
        chk("rst_ovf", 32'(evt_overflow), 32'd0);
        reset_n = 1'b1;
        step(1);
        chk("init_cs", 32'(m_chipselect), 32'd1);
        chk("init_wn", 32'(m_write_n), 32'd0);
        chk("init_addr", 32'(m_address), 32'd2);
        chk("init_wdata", m_writedata, 32'h1);
        step(1);
        chk("idle_cs", 32'(m_chipselect), 32'd0);
        chk("idle_addr", 32'(m_address), 32'd3);
`ifdef KEY_EVT_POLL_EN
        first = 0;
        second = 0;
        for (int e = 3; e <= 30; e++) begin
            step(1);
            if (m_chipselect && m_write_n && m_address == 2'd3) begin
                if (first == 0) first = e;
                else if (second == 0) second = e;
            end
        end
        chk("poll_first_rd", 32'(first), 32'd9);
        chk("poll_second_rd", 32'(second), 32'd19);
`else
        act = 0;
        for (int e = 0; e < 30; e++) begin
            step(1);
            if (m_chipselect) act++;
        end
        chk("no_poll_activity", 32'(act), 32'd0);
        ec_set = 1'b1;
        din = 1'b1;
        step(1);
        ec_set = 1'b0;
        step(1);
        chk("rdec_cs", 32'(m_chipselect), 32'd1);
        chk("rdec_addr", 32'(m_address), 32'd3);
        step(1);
        chk("wtec_cs", 32'(m_chipselect), 32'd0);
        chk("wtec_addr", 32'(m_address), 32'd3);
        step(1);
        chk("clr_cs", 32'(m_chipselect), 32'd1);
        chk("clr_wn", 32'(m_write_n), 32'd0);
        chk("clr_addr", 32'(m_address), 32'd3);
        chk("clr_wdata", m_writedata, 32'd0);
        step(1);
        chk("rddat_cs", 32'(m_chipselect), 32'd1);
        chk("rddat_wn", 32'(m_write_n), 32'd1);
        chk("rddat_addr", 32'(m_address), 32'd0);
        step(2);
        chk("push_valid_pre", 32'(evt_valid), 32'd0);
        step(1);
        chk("evt_valid", 32'(evt_valid), 32'd1);
        chk("evt_level", 32'(evt_level), 32'd1);
        chk("back_idle_cs", 32'(m_chipselect), 32'd0);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("popped_empty", 32'(evt_valid), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("fill4_ovf", 32'(evt_overflow), 32'd0);
        press(1'b0, 1'b0, 1'b0);
        chk("drop_ovf", 32'(evt_overflow), 32'd1);
        chk("drop_head", 32'(evt_level), 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(evt_overflow), 32'd0);
        drain4("ovf_q", 4'b1101);
        press(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        chk("pushpop_ovf", 32'(evt_overflow), 32'd0);
        drain4("pushpop_q", 4'b1101);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("set_wins_ovf", 32'(evt_overflow), 32'd1);
        drain4("setwin_q", 4'b1111);
        rd = 0;
        wr = 0;
        irq_force = 1'b1;
        for (int e = 0; e < 21; e++) begin
            step(1);
            if (m_chipselect && m_write_n && m_address == 2'd3) rd++;
            if (!m_write_n) wr++;
        end
        irq_force = 1'b0;
        chk("irq_hold_reads", 32'(rd), 32'd7);
        chk("irq_hold_writes", 32'(wr), 32'd0);
        chk("irq_hold_noevt", 32'(evt_valid), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        ec_set = 1'b1;
        din = 1'b1;
        step(1);
        ec_set = 1'b0;
        step(5);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(evt_valid), 32'd0);
        chk("midrst_ovf", 32'(evt_overflow), 32'd0);
        chk("midrst_cs", 32'(m_chipselect), 32'd0);
        chk("midrst_wn", 32'(m_write_n), 32'd1);
        chk("midrst_addr", 32'(m_address), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(1);
        chk("reinit_wn", 32'(m_write_n), 32'd0);
        chk("reinit_addr", 32'(m_address), 32'd2);
        step(1);
        chk("reinit_idle_cs", 32'(m_chipselect), 32'd0);
        step(6);
        chk("midrst_nopush", 32'(evt_valid), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
